// File: rtl/qspi_ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM sequencer port around qspi_ram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic (requesters + sequencer).
interface qspi_ram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 8
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [LEN_W-1:0]  a_len;
    logic              a_ack;
    logic [7:0]        a_rdata;
    logic              a_rvalid;
    logic              a_done;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [LEN_W-1:0]  b_len;
    logic [7:0]        b_wdata;
    logic              b_wready;
    logic              b_ack;
    logic [7:0]        b_rdata;
    logic              b_rvalid;
    logic              b_done;

    logic              m_start;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    logic [7:0]        m_wdata;
    logic              m_wready;
    logic [7:0]        m_rdata;
    logic              m_rvalid;
    logic              m_busy;
    logic              m_done;

    logic [1:0]        owner;
    logic [4:0]        starve_cnt;

    modport slave (
        input  a_req, a_addr, a_len,
        output a_ack, a_rdata, a_rvalid, a_done,
        input  b_req, b_we, b_addr, b_len, b_wdata,
        output b_wready, b_ack, b_rdata, b_rvalid, b_done,
        output m_start, m_we, m_addr, m_len, m_wdata,
        input  m_wready, m_rdata, m_rvalid, m_busy, m_done,
        output owner, starve_cnt
    );

    modport master (
        output a_req, a_addr, a_len,
        input  a_ack, a_rdata, a_rvalid, a_done,
        output b_req, b_we, b_addr, b_len, b_wdata,
        input  b_wready, b_ack, b_rdata, b_rvalid, b_done,
        input  m_start, m_we, m_addr, m_len, m_wdata,
        output m_wready, m_rdata, m_rvalid, m_busy, m_done,
        input  owner, starve_cnt
    );
endinterface

// File: rtl/qspi_ram_arbiter.sv
// Two-port arbiter in front of one quad-SPI RAM sequencer: A (flash emulation, high priority,
// read only) and B (host, read/write), burst-granular grants with a starvation guard for B.
module qspi_ram_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    qspi_ram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN_A = 2'd1,
        S_RUN_B = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_A      = 2'b01;
    localparam logic [1:0] OWN_B      = 2'b10;
    localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

    state_t            r_state;
    logic [1:0]        r_owner;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_a_done;
    logic              r_b_done;
    logic              r_m_start;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [LEN_W-1:0]  r_m_len;
    logic [4:0]        r_starve;

    logic w_b_wins;
    logic w_own_a;
    logic w_own_b;

    // B takes the slot when A is absent or A has used up its consecutive-grant allowance.
    assign w_b_wins = bus.b_req && ((r_starve == STARVE_LIM) || !bus.a_req);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_NONE;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_m_start <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_len   <= '0;
            r_starve  <= '0;
        end else begin
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_m_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.m_busy) begin
                        if (w_b_wins) begin
                            r_b_ack   <= 1'b1;
                            r_m_start <= 1'b1;
                            r_m_we    <= bus.b_we;
                            r_m_addr  <= bus.b_addr;
                            r_m_len   <= bus.b_len;
                            r_owner   <= OWN_B;
                            r_starve  <= '0;
                            r_state   <= S_RUN_B;
                        end else if (bus.a_req) begin
                            r_a_ack   <= 1'b1;
                            r_m_start <= 1'b1;
                            r_m_we    <= 1'b0;
                            r_m_addr  <= bus.a_addr;
                            r_m_len   <= bus.a_len;
                            r_owner   <= OWN_A;
                            r_state   <= S_RUN_A;
                            if (!bus.b_req)
                                r_starve <= '0;
                            else if (r_starve != STARVE_LIM)
                                r_starve <= r_starve + 5'd1;
                        end
                    end
                end
                // Returning to IDLE for one cycle gives the bus its release turnaround.
                S_RUN_A: begin
                    if (bus.m_done) begin
                        r_a_done <= 1'b1;
                        r_owner  <= OWN_NONE;
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN_B: begin
                    if (bus.m_done) begin
                        r_b_done <= 1'b1;
                        r_owner  <= OWN_NONE;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_own_a = (r_owner == OWN_A);
    assign w_own_b = (r_owner == OWN_B);

    assign bus.a_ack      = r_a_ack;
    assign bus.b_ack      = r_b_ack;
    assign bus.a_done     = r_a_done;
    assign bus.b_done     = r_b_done;
    assign bus.m_start    = r_m_start;
    assign bus.m_we       = r_m_we;
    assign bus.m_addr     = r_m_addr;
    assign bus.m_len      = r_m_len;
    assign bus.owner      = r_owner;
    assign bus.starve_cnt = r_starve;

    // Read data and write handshake follow the current owner; idle-time beats are discarded.
    assign bus.a_rvalid = w_own_a & bus.m_rvalid;
    assign bus.a_rdata  = w_own_a ? bus.m_rdata : 8'h00;
    assign bus.b_rvalid = w_own_b & bus.m_rvalid;
    assign bus.b_rdata  = w_own_b ? bus.m_rdata : 8'h00;
    assign bus.b_wready = w_own_b & bus.m_wready;
    assign bus.m_wdata  = bus.b_wdata;
endmodule

// File: tb/tb_qspi_ram_arbiter.sv
// Directed bench for qspi_ram_arbiter: a table of single-burst arbitration vectors
// followed by hand-written sequences for turnaround, busy, write routing and reset.
module tb_qspi_ram_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    qspi_ram_arbiter_if #(.ADDR_W(24), .LEN_W(8)) bus ();

    qspi_ram_arbiter #(.ADDR_W(24), .LEN_W(8), .STARVE_MAX(3)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_req;
        logic        b_req;
        logic        b_we;
        logic [23:0] a_addr;
        logic [23:0] b_addr;
        logic [1:0]  exp_owner;
        logic        exp_we;
        logic [23:0] exp_addr;
        logic [7:0]  exp_len;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic ar, input logic br, input logic bw,
                                input logic [23:0] aa, input logic [23:0] ba,
                                input logic [1:0] eo, input logic ew,
                                input logic [23:0] ea, input logic [7:0] el,
                                input logic [4:0] ec);
        vec_t v;
        v.a_req = ar; v.b_req = br; v.b_we = bw; v.a_addr = aa; v.b_addr = ba;
        v.exp_owner = eo; v.exp_we = ew; v.exp_addr = ea; v.exp_len = el; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic end_burst(input logic [1:0] own);
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        chk("a_done", 32'(bus.a_done), 32'(own == 2'b01));
        chk("b_done", 32'(bus.b_done), 32'(own == 2'b10));
        chk("owner_after_done", 32'(bus.owner), 32'd0);
        tick();
        chk("done_pulse_width", 32'(bus.a_done | bus.b_done), 32'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic [7:0] rd;
        v = vecs[i];
        rd = 8'hA0 + 8'(i);
        bus.a_req = v.a_req; bus.b_req = v.b_req; bus.b_we = v.b_we;
        bus.a_addr = v.a_addr; bus.b_addr = v.b_addr;
        bus.a_len = 8'h04; bus.b_len = 8'h02;
        tick();
        chk($sformatf("v%0d_owner", i), 32'(bus.owner), 32'(v.exp_owner));
        chk($sformatf("v%0d_m_start", i), 32'(bus.m_start), 32'(v.exp_owner != 2'b00));
        chk($sformatf("v%0d_a_ack", i), 32'(bus.a_ack), 32'(v.exp_owner == 2'b01));
        chk($sformatf("v%0d_b_ack", i), 32'(bus.b_ack), 32'(v.exp_owner == 2'b10));
        chk($sformatf("v%0d_starve", i), 32'(bus.starve_cnt), 32'(v.exp_cnt));
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        if (v.exp_owner != 2'b00) begin
            chk($sformatf("v%0d_m_addr", i), 32'(bus.m_addr), 32'(v.exp_addr));
            chk($sformatf("v%0d_m_len", i), 32'(bus.m_len), 32'(v.exp_len));
            chk($sformatf("v%0d_m_we", i), 32'(bus.m_we), 32'(v.exp_we));
            tick();
            chk($sformatf("v%0d_start_pulse", i), 32'(bus.m_start | bus.a_ack | bus.b_ack), 32'd0);
            bus.m_rdata = rd; bus.m_rvalid = 1'b1;
            #1;
            chk($sformatf("v%0d_a_rvalid", i), 32'(bus.a_rvalid), 32'(v.exp_owner == 2'b01));
            chk($sformatf("v%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(v.exp_owner == 2'b10));
            chk($sformatf("v%0d_rdata", i),
                32'((v.exp_owner == 2'b01) ? bus.a_rdata : bus.b_rdata), 32'(rd));
            tick();
            bus.m_rvalid = 1'b0;
            end_burst(v.exp_owner);
        end else begin
            tick();
        end
        $display("[TB] vec %0d: a_req=%0d b_req=%0d -> owner=%0d starve=%0d",
                 i, v.a_req, v.b_req, v.exp_owner, v.exp_cnt);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.a_req = 0; bus.a_addr = '0; bus.a_len = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_len = '0; bus.b_wdata = '0;
        bus.m_wready = 0; bus.m_rdata = '0; bus.m_rvalid = 0; bus.m_busy = 0; bus.m_done = 0;

        // Vectors assume STARVE_MAX=3; counts are hand-derived in sequence.
        vecs[0] = mk(1, 0, 0, 24'h012345, 24'h000000, 2'b01, 0, 24'h012345, 8'h04, 5'd0);
        vecs[1] = mk(0, 1, 0, 24'h000000, 24'h000100, 2'b10, 0, 24'h000100, 8'h02, 5'd0);
        vecs[2] = mk(1, 1, 1, 24'h100000, 24'h200000, 2'b01, 0, 24'h100000, 8'h04, 5'd1);
        vecs[3] = mk(1, 1, 1, 24'h100010, 24'h200010, 2'b01, 0, 24'h100010, 8'h04, 5'd2);
        vecs[4] = mk(1, 1, 1, 24'h100020, 24'h200020, 2'b01, 0, 24'h100020, 8'h04, 5'd3);
        vecs[5] = mk(1, 1, 1, 24'h100030, 24'h200030, 2'b10, 1, 24'h200030, 8'h02, 5'd0);
        vecs[6] = mk(1, 1, 0, 24'h100040, 24'h200040, 2'b01, 0, 24'h100040, 8'h04, 5'd1);
        vecs[7] = mk(1, 0, 0, 24'h100050, 24'h200050, 2'b01, 0, 24'h100050, 8'h04, 5'd0);
        vecs[8] = mk(0, 1, 1, 24'h100060, 24'hABCDEF, 2'b10, 1, 24'hABCDEF, 8'h02, 5'd0);
        vecs[9] = mk(0, 0, 0, 24'h100070, 24'h200070, 2'b00, 0, 24'h000000, 8'h00, 5'd0);

        #1;
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_m_start", 32'(bus.m_start), 32'd0);
        chk("rst_m_addr", 32'(bus.m_addr), 32'd0);
        chk("rst_starve", 32'(bus.starve_cnt), 32'd0);
        $display("[TB] reset: owner=%0d starve=%0d", bus.owner, bus.starve_cnt);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i);

        // A and B together: A first, B granted on the second cycle after m_done.
        bus.a_req = 1; bus.b_req = 1; bus.b_we = 0; bus.a_addr = 24'h000AAA; bus.b_addr = 24'h000BBB;
        tick();
        chk("turn_a_ack", 32'(bus.a_ack), 32'd1);
        chk("turn_starve", 32'(bus.starve_cnt), 32'd1);
        bus.a_req = 0;
        tick(); tick();
        bus.m_done = 1;
        tick();
        bus.m_done = 0;
        chk("turn_a_done", 32'(bus.a_done), 32'd1);
        chk("turn_no_b_ack_m1", 32'(bus.b_ack | bus.m_start), 32'd0);
        tick();
        chk("turn_b_ack_m2", 32'(bus.b_ack), 32'd1);
        chk("turn_m_start_m2", 32'(bus.m_start), 32'd1);
        chk("turn_m_addr", 32'(bus.m_addr), 32'h000BBB);
        bus.b_req = 0;
        end_burst(2'b10);
        $display("[TB] turnaround: A then B two cycles after m_done");

        // B write: wready gated to B, wdata passes through, A sees no read beats.
        bus.b_req = 1; bus.b_we = 1; bus.b_len = 8'h02; bus.b_addr = 24'h00C0DE;
        tick();
        chk("wr_b_ack", 32'(bus.b_ack), 32'd1);
        chk("wr_m_we", 32'(bus.m_we), 32'd1);
        bus.b_req = 0;
        for (int k = 0; k < 4; k++) begin
            bus.m_wready = k[0];
            bus.m_rvalid = ~k[0];
            bus.b_wdata  = 8'h30 + 8'(k);
            #1;
            chk("wr_b_wready", 32'(bus.b_wready), 32'(k[0]));
            chk("wr_m_wdata", 32'(bus.m_wdata), 32'(8'h30 + 8'(k)));
            chk("wr_a_rvalid", 32'(bus.a_rvalid), 32'd0);
            tick();
        end
        bus.m_wready = 0; bus.m_rvalid = 0;
        end_burst(2'b10);
        $display("[TB] B write routing done");

        // Busy sequencer blocks arbitration until m_busy falls.
        bus.m_busy = 1; bus.a_req = 1; bus.a_addr = 24'h0000F0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("busy_no_ack", 32'(bus.a_ack | bus.m_start), 32'd0);
        end
        bus.m_busy = 0;
        tick();
        chk("busy_release_ack", 32'(bus.a_ack), 32'd1);
        bus.a_req = 0;
        end_burst(2'b01);
        $display("[TB] busy hold then A grant");

        // Spurious m_done and m_rvalid while idle are ignored.
        bus.m_done = 1; bus.m_rvalid = 1; bus.m_rdata = 8'h77;
        #1;
        chk("idle_rvalid", 32'(bus.a_rvalid | bus.b_rvalid), 32'd0);
        tick();
        chk("idle_spurious_done", 32'(bus.a_done | bus.b_done), 32'd0);
        bus.m_done = 0; bus.m_rvalid = 0;
        tick();
        $display("[TB] spurious idle events ignored");

        // Asynchronous reset in the B grant cycle, then a fresh A grant.
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 24'h00DEAD;
        tick();
        chk("rstmid_b_ack", 32'(bus.b_ack), 32'd1);
        bus.b_req = 0; bus.m_wready = 1;
        #2;
        rst_n = 0;
        #1;
        chk("rstmid_owner", 32'(bus.owner), 32'd0);
        chk("rstmid_m_start", 32'(bus.m_start), 32'd0);
        chk("rstmid_b_wready", 32'(bus.b_wready), 32'd0);
        chk("rstmid_m_we", 32'(bus.m_we), 32'd0);
        chk("rstmid_starve", 32'(bus.starve_cnt), 32'd0);
        tick();
        rst_n = 1; bus.m_wready = 0; bus.a_req = 1; bus.a_addr = 24'h000123;
        tick();
        chk("rstmid_a_ack", 32'(bus.a_ack), 32'd1);
        chk("rstmid_a_addr", 32'(bus.m_addr), 32'h000123);
        bus.a_req = 0;
        end_burst(2'b01);
        $display("[TB] reset mid-burst recovered");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
